// File: rtl/mult_pp_pkg.sv
// Shared definitions for the mult_pp_pipe partial-product multiplier.
// The op encoding is common to both builds; MULT_PP_HIGH_EN only changes how ops are interpreted.
package mult_pp_pkg;
  localparam int OP_W         = 2;
  localparam int PIPE_LATENCY = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;
endpackage

// File: rtl/mult_pp_half.sv
// One registered unsigned HALF_W x HALF_W multiplier; the product loads only when en is high.
module mult_pp_half #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);
  always_ff @(posedge clk) begin
    if (en) p <= (2*HALF_W)'(a) * (2*HALF_W)'(b);
  end
endmodule

// File: rtl/mult_pp_pipe.sv
// Two-stage elastic multiplier: S1 registers half-width partial products, S2 the selected word.
// Define MULT_PP_HIGH_EN to add the hh product, signed correction and the MULX high-word ops.
module mult_pp_pipe
  import mult_pp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);
  localparam int HALF_W = DATA_W / 2;

  logic              vld_p1, vld_p2;
  logic              adv_p1, accept;
  logic [DATA_W-1:0] ll_p1, lh_p1, hl_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] result_p1;

  // S1 drains into S2 whenever S2 is empty or being taken this cycle.
  assign adv_p1    = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready  = !reset && (!vld_p1 || adv_p1);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p2;
  assign busy      = vld_p1 || vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept)      vld_p1 <= 1'b1;
      else if (adv_p1) vld_p1 <= 1'b0;
      if (adv_p1)                  vld_p2 <= 1'b1;
      else if (vld_p2 && out_ready) vld_p2 <= 1'b0;
    end
  end

  // ---- stage p0 -> p1: partial products and request side-band ----
  mult_pp_half #(.HALF_W(HALF_W)) u_ll (
    .clk (clk), .en (accept),
    .a   (in_src1[HALF_W-1:0]), .b (in_src2[HALF_W-1:0]), .p (ll_p1)
  );
  mult_pp_half #(.HALF_W(HALF_W)) u_lh (
    .clk (clk), .en (accept),
    .a   (in_src1[HALF_W-1:0]), .b (in_src2[DATA_W-1:HALF_W]), .p (lh_p1)
  );
  mult_pp_half #(.HALF_W(HALF_W)) u_hl (
    .clk (clk), .en (accept),
    .a   (in_src1[DATA_W-1:HALF_W]), .b (in_src2[HALF_W-1:0]), .p (hl_p1)
  );

  always_ff @(posedge clk) begin
    if (accept) tag_p1 <= in_tag;
  end

`ifdef MULT_PP_HIGH_EN
  logic [DATA_W-1:0]   hh_p1;
  logic [DATA_W-1:0]   corr_p0, corr_p1;
  op_e                 op_p1;
  logic [2*DATA_W-1:0] prod_p1;
  logic                sgn1_p0, sgn2_p0;

  mult_pp_half #(.HALF_W(HALF_W)) u_hh (
    .clk (clk), .en (accept),
    .a   (in_src1[DATA_W-1:HALF_W]), .b (in_src2[DATA_W-1:HALF_W]), .p (hh_p1)
  );

  // Unsigned partials overestimate a negative operand by 2^DATA_W times the other one;
  // the high word is corrected by subtracting that term.
  always_comb begin
    sgn1_p0 = (in_op == OP_MULXSS) || (in_op == OP_MULXSU);
    sgn2_p0 = (in_op == OP_MULXSS);
    corr_p0 = '0;
    if (sgn1_p0 && in_src1[DATA_W-1]) corr_p0 = corr_p0 + in_src2;
    if (sgn2_p0 && in_src2[DATA_W-1]) corr_p0 = corr_p0 + in_src1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1   <= op_e'(in_op);
      corr_p1 <= corr_p0;
    end
  end

  function automatic logic [DATA_W-1:0] select_word(input op_e op,
                                                    input logic [2*DATA_W-1:0] prod,
                                                    input logic [DATA_W-1:0] corr);
    if (op == OP_MUL) return prod[DATA_W-1:0];
    return prod[2*DATA_W-1:DATA_W] - corr;
  endfunction

  always_comb begin
    prod_p1 = {hh_p1, ll_p1}
            + {{HALF_W{1'b0}}, lh_p1, {HALF_W{1'b0}}}
            + {{HALF_W{1'b0}}, hl_p1, {HALF_W{1'b0}}};
    result_p1 = select_word(op_p1, prod_p1, corr_p1);
  end
`else
  logic unused_hi;

  // Only the low word is produced, so the cross products' upper halves and the op never matter.
  assign unused_hi = ^{in_op, lh_p1[DATA_W-1:HALF_W], hl_p1[DATA_W-1:HALF_W]};

  always_comb begin
    result_p1 = ll_p1
              + {lh_p1[HALF_W-1:0], {HALF_W{1'b0}}}
              + {hl_p1[HALF_W-1:0], {HALF_W{1'b0}}};
  end
`endif

  // ---- stage p1 -> p2: result word held until the consumer takes it ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv_p1) begin
      out_result <= result_p1;
      out_tag    <= tag_p1;
    end
  end
endmodule

// File: tb/tb_mult_pp_pipe.sv
// Randomized and directed bench for mult_pp_pipe (DATA_W=32) with a queue-based reference model.
module tb_mult_pp_pipe;
  import mult_pp_pkg::*;

`ifdef MULT_PP_HIGH_EN
  localparam bit HIGH = 1'b1;
`else
  localparam bit HIGH = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_op = '0;
  logic [31:0]       in_src1 = '0, in_src2 = '0;
  logic [4:0]        in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_result;
  logic [4:0]        out_tag;
  logic              busy;

  mult_pp_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0;
  logic [4:0]  tag_ctr = '0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Mathematical product of the operands under the op's signedness, then word selection.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    if (!HIGH) begin
      p = $signed({34'b0, a}) * $signed({34'b0, b});
      return p[31:0];
    end
    sa = (op == OP_MULXSS || op == OP_MULXSU) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (op == OP_MULXSS) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit ordy, input bit lit, input logic [31:0] lit_v, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag_ctr; out_ready = ordy;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_result", out_result, prev_res);
      check("hold_tag", out_tag, prev_tag);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("result", out_result, e.res);
        check("tag", out_tag, e.tag);
        if (lat_chk) check("latency", cyc - e.cyc, 2);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_res   = out_result;
    prev_tag   = out_tag;
    acc = in_valid && in_ready;
    if (acc) begin
      e.tag = tag_ctr;
      e.res = lit ? lit_v : model(op, a, b);
      e.cyc = cyc;
      sb_q.push_back(e);
      tag_ctr++;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, '0, acc);
  endtask

  task automatic send_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_v);
    bit acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) drive(1'b1, op, a, b, 1'b1, 1'b1, lit_v, acc);
    if (!acc) check("accept_timeout", 0, 1);
    idle(3);
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    check(name, sb_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_result", out_result, 0);
    check("post_rst_tag", out_tag, 0);
    sb_q.delete();
    prev_stall = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    logic [31:0] a, b;
    do_reset(3);

    send_one(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    send_one(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, HIGH ? 32'hFFFF_FFFE : 32'h0000_0001);
    send_one(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, HIGH ? 32'h0000_0000 : 32'h0000_0001);
    send_one(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, HIGH ? 32'hFFFF_FFFF : 32'h0000_0001);
    send_one(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, HIGH ? 32'h4000_0000 : 32'h0000_0000);
    send_one(OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000);

    // Back-to-back burst with tags 0..7: each result exactly two cycles after its accept.
    drain_all("pre_burst_empty");
    tag_ctr = '0;
    lat_chk = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'($urandom), $urandom, $urandom, 1'b1, 1'b0, '0, acc);
      n_acc += int'(acc);
    end
    check("burst_accepts", n_acc, 8);
    idle(4);
    lat_chk = 1'b0;
    check("burst_empty", sb_q.size(), 0);

    // Consumer stall from empty: two accepts fill S1 and S2, then in_ready drops.
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0, '0, acc);
      n_acc += int'(acc);
    end
    check("stall_accepts", n_acc, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_busy", busy, 1);
    drain_all("stall_drained");

    // Reset with two entries in flight: nothing may emerge afterwards.
    drive(1'b1, OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0, '0, acc);
    drive(1'b1, OP_MUL, 32'd7, 32'd9, 1'b0, 1'b0, '0, acc);
    check("inflight_busy", busy, 1);
    do_reset(1);
    idle(6);
    check("post_flush_busy", busy, 0);

    // Random traffic with random back-pressure and corner-biased operands.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
        2: a = $urandom_range(0, 300);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, 2'($urandom), a, b, $urandom_range(0, 3) != 0, 1'b0, '0, acc);
    end
    drain_all("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
